// File: rtl/io_bus_master.sv
// io_bus_master: CPU request port to a wait-stated peripheral bus (ABUS/DBUS/WE).
// Define POSTED_WRITE_EN to compile in a 2-entry posted-write FIFO.
module io_bus_master #(
    parameter int unsigned     BITS        = 32,
    parameter int unsigned     WAIT_CYCLES = 1,
    parameter logic [BITS-1:0] IDLE_ADDR   = '1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            REQ,
    input  logic            REQ_WE,
    input  logic [BITS-1:0] REQ_ADDR,
    input  logic [BITS-1:0] REQ_WDATA,
    output logic            READY,
    output logic            RSP_VALID,
    output logic [BITS-1:0] RSP_RDATA,
    output logic [BITS-1:0] ABUS,
    inout  wire  [BITS-1:0] DBUS,
    output logic            WE
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_TURN   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [BITS-1:0]  addr_q, addr_d;
    logic [BITS-1:0]  wdata_q, wdata_d;
    logic [BITS-1:0]  rdata_q, rdata_d;

`ifdef POSTED_WRITE_EN
    localparam int unsigned DEPTH = 2;

    logic [BITS-1:0] fifo_addr_q [DEPTH];
    logic [BITS-1:0] fifo_data_q [DEPTH];
    logic [1:0]      count_q, count_d;
    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic            rd_pend_q, rd_pend_d;
    logic [BITS-1:0] rd_addr_q, rd_addr_d;
    logic            accept_c;
    logic            push_c;
    logic            pop_c;

    // A write stays in the FIFO until its TURN cycle, so the in-flight entry counts as occupied
    assign READY    = (count_q != 2'd2) && !rd_pend_q;
    assign accept_c = REQ && READY;
    assign push_c   = accept_c && REQ_WE;
    assign pop_c    = (state_q == S_TURN) && we_q;

    always_comb begin
        count_d   = count_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        if (push_c) begin
            wptr_d = ~wptr_q;
        end
        if (pop_c) begin
            rptr_d = ~rptr_q;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = 2'(count_q + 2'd1);
            2'b01:   count_d = 2'(count_q - 2'd1);
            default: count_d = count_q;
        endcase
        if (accept_c && !REQ_WE) begin
            rd_pend_d = 1'b1;
            rd_addr_d = REQ_ADDR;
        end else if ((state_q == S_TURN) && !we_q) begin
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            count_q   <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            if (push_c) begin
                fifo_addr_q[wptr_q] <= REQ_ADDR;
                fifo_data_q[wptr_q] <= REQ_WDATA;
            end
        end
    end

    assign RSP_VALID = (state_q == S_TURN) && !we_q;
`else
    assign READY     = (state_q == S_IDLE);
    assign RSP_VALID = (state_q == S_TURN);
`endif

    // Next-state: IDLE picks up work, ACCESS counts down, TURN returns the bus to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
`ifdef POSTED_WRITE_EN
                if (count_q != 2'd0) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_LOAD;
                    we_d    = 1'b1;
                    addr_d  = fifo_addr_q[rptr_q];
                    wdata_d = fifo_data_q[rptr_q];
                end else if (rd_pend_q) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_LOAD;
                    we_d    = 1'b0;
                    addr_d  = rd_addr_q;
                end
`else
                if (REQ) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_LOAD;
                    we_d    = REQ_WE;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                end
`endif
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_TURN;
                    if (!we_q) begin
                        rdata_d = DBUS;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q - 4'd1);
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus pins decode from registered state only
    assign ABUS      = (state_q == S_ACCESS) ? addr_q : IDLE_ADDR;
    assign WE        = (state_q == S_ACCESS) && we_q;
    assign DBUS      = WE ? wdata_q : {BITS{1'bz}};
    assign RSP_RDATA = rdata_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed latency/reset cases plus random traffic
// checked every cycle against a transaction-queue model.
module tb_io_bus_master;

    localparam int unsigned BITS = 32;
    localparam int          W    = 1;
`ifdef POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    localparam int          OFS  = POSTED ? 1 : 0;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req = 1'b0, req_we = 1'b0;
    logic [31:0]     req_addr = '0, req_wdata = '0;
    logic            ready, rsp_valid, we;
    logic [31:0]     rsp_rdata, abus;
    wire  [31:0]     dbus;
    logic            tb_drv = 1'b1;
    logic [31:0]     tb_val = '0;
    logic            fix_en = 1'b0;
    logic [31:0]     fix_val = '0;

    logic            req0 = 1'b0;
    logic [31:0]     addr0 = '0;
    logic            ready0, rsp_valid0, we0;
    logic [31:0]     rsp_rdata0, abus0;
    wire  [31:0]     dbus0;
    logic            tb_drv0 = 1'b1;
    logic [31:0]     tb_val0 = 32'h0000_5A5A;

    int n_cmp = 0;
    int n_bad = 0;

    assign dbus  = tb_drv  ? tb_val  : 'z;
    assign dbus0 = tb_drv0 ? tb_val0 : 'z;

    always #5 clk = ~clk;

    io_bus_master #(.BITS(BITS), .WAIT_CYCLES(W), .IDLE_ADDR(ONES)) u_dut (
        .CLK(clk), .RESET_N(rst_n), .REQ(req), .REQ_WE(req_we), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .READY(ready), .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
        .ABUS(abus), .DBUS(dbus), .WE(we)
    );

    io_bus_master #(.BITS(BITS), .WAIT_CYCLES(0), .IDLE_ADDR(ONES)) u_dut0 (
        .CLK(clk), .RESET_N(rst_n), .REQ(req0), .REQ_WE(1'b0), .REQ_ADDR(addr0),
        .REQ_WDATA(32'h0), .READY(ready0), .RSP_VALID(rsp_valid0), .RSP_RDATA(rsp_rdata0),
        .ABUS(abus0), .DBUS(dbus0), .WE(we0)
    );

    // Model: queue of accepted, uncompleted transfers; head is on the bus while active.
    // phase 0..W is ACCESS, phase W+1 is the turnaround cycle.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         pend[$];
    bit          active = 1'b0;
    int          phase = 0;
    logic [31:0] rdata_m = '0;
    bit          live = 1'b0;

    function automatic bit model_ready();
        int nw;
        bit hr;
        nw = 0;
        hr = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].we) nw++;
            else hr = 1'b1;
        end
        if (POSTED) return (nw < 2) && !hr;
        return pend.size() == 0;
    endfunction

    task automatic model_step();
        bit rdy;
        op_t op;
        if (!rst_n) begin
            pend.delete();
            active  = 1'b0;
            phase   = 0;
            rdata_m = '0;
            live    = 1'b1;
            return;
        end
        rdy = model_ready();
        if (active) begin
            if (phase == W + 1) begin
                void'(pend.pop_front());
                active = 1'b0;
            end else begin
                if (phase == W && !pend[0].we) rdata_m = tb_val;
                phase++;
            end
        end else if (POSTED && pend.size() != 0) begin
            active = 1'b1;
            phase  = 0;
        end
        if (req && rdy) begin
            op.we   = req_we;
            op.addr = req_addr;
            op.data = req_wdata;
            pend.push_back(op);
            if (!POSTED) begin
                active = 1'b1;
                phase  = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge, then the peripheral side drives DBUS for the new cycle
    initial begin
        forever begin
            @(posedge clk);
            if (live || !rst_n) model_step();
            #1;
            tb_drv = !(active && phase <= W && pend[0].we);
            tb_val = fix_en ? fix_val : $urandom();
        end
    end

    // Every-cycle compare against the model
    initial begin
        bit          acc;
        logic        e_we;
        logic [31:0] e_abus, e_dbus;
        logic        e_valid;
        forever begin
            @(negedge clk);
            if (live) begin
                acc     = active && phase <= W;
                e_abus  = acc ? pend[0].addr : ONES;
                e_we    = acc && pend[0].we;
                e_dbus  = e_we ? pend[0].data : tb_val;
                e_valid = active && phase == W + 1 && (!POSTED || !pend[0].we);
                chk("ready", 32'(ready), 32'(model_ready()));
                chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
                chk("rsp_rdata", rsp_rdata, rdata_m);
                chk("abus", abus, e_abus);
                chk("we", 32'(we), 32'(e_we));
                chk("dbus", dbus, e_dbus);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int pulses;
        repeat (2) tick();
        rst_n = 1'b1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_abus", abus, ONES);
        chk("rst_we", 32'(we), 32'd0);
        tick();

        // Write 5 to F000_0000
        req = 1'b1; req_we = 1'b1; req_addr = 32'hF000_0000; req_wdata = 32'h5;
        tick();
        req = 1'b0; req_addr = 32'h1111_1111; req_wdata = 32'h2222_2222;
        if (!POSTED) chk("wr_ready_busy", 32'(ready), 32'd0);
        repeat (OFS) tick();
        chk("wr_we1", 32'(we), 32'd1);
        chk("wr_dbus1", dbus, 32'h5);
        chk("wr_abus1", abus, 32'hF000_0000);
        tick();
        chk("wr_we2", 32'(we), 32'd1);
        chk("wr_dbus2", dbus, 32'h5);
        tick();
        chk("wr_turn_valid", 32'(rsp_valid), POSTED ? 32'd0 : 32'd1);
        chk("wr_turn_abus", abus, ONES);
        chk("wr_turn_we", 32'(we), 32'd0);
        tick();
        chk("wr_ready_back", 32'(ready), 32'd1);
        chk("wr_valid_gone", 32'(rsp_valid), 32'd0);

        // Read F000_0004 with the peripheral returning 0x1234
        fix_en = 1'b1; fix_val = 32'h1234;
        req = 1'b1; req_we = 1'b0; req_addr = 32'hF000_0004;
        tick();
        req = 1'b0;
        repeat (OFS) tick();
        chk("rd_abus", abus, 32'hF000_0004);
        chk("rd_we", 32'(we), 32'd0);
        chk("rd_dbus1", dbus, 32'h1234);
        tick();
        chk("rd_dbus2", dbus, 32'h1234);
        tick();
        chk("rd_valid", 32'(rsp_valid), 32'd1);
        chk("rd_data", rsp_rdata, 32'h1234);
        fix_en = 1'b0;
        tick();

        // A write leaves read data alone
        req = 1'b1; req_we = 1'b1; req_addr = 32'hF000_0010; req_wdata = 32'hDEAD_BEEF;
        tick();
        req = 1'b0;
        repeat (4 + OFS) tick();
        chk("wr_keeps_rdata", rsp_rdata, 32'h1234);

        // Reset in the second ACCESS cycle of a write
        req = 1'b1; req_we = 1'b1; req_addr = 32'hF000_0020; req_wdata = 32'h77;
        tick();
        req = 1'b0;
        repeat (OFS) tick();
        tick();
        chk("abort_we_before", 32'(we), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_abus", abus, ONES);
        chk("abort_rdata", rsp_rdata, 32'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        chk("abort_no_valid", 32'(pulses), 32'd0);

`ifndef POSTED_WRITE_EN
        // REQ held high across two writes
        req = 1'b1; req_we = 1'b1; req_addr = 32'hA000_0000; req_wdata = 32'hAAAA;
        tick();
        req_addr = 32'hB000_0000; req_wdata = 32'hBBBB;
        chk("b2b_abus_a1", abus, 32'hA000_0000);
        tick();
        chk("b2b_abus_a2", abus, 32'hA000_0000);
        tick();
        chk("b2b_turn_abus", abus, ONES);
        chk("b2b_turn_ready", 32'(ready), 32'd0);
        tick();
        chk("b2b_ready", 32'(ready), 32'd1);
        tick();
        req = 1'b0;
        chk("b2b_abus_b", abus, 32'hB000_0000);
        chk("b2b_dbus_b", dbus, 32'hBBBB);
        repeat (4) tick();
`else
        // Posted: writes A, B then read C
        pulses = 0;
        req = 1'b1; req_we = 1'b1; req_addr = 32'hA000_0000; req_wdata = 32'hAAAA;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (rsp_valid) pulses++;
            case (k)
                1: begin
                    chk("pw_ready1", 32'(ready), 32'd1);
                    req_addr = 32'hB000_0000; req_wdata = 32'hBBBB;
                end
                2: begin
                    chk("pw_full", 32'(ready), 32'd0);
                    chk("pw_abus_a", abus, 32'hA000_0000);
                    req_we = 1'b0; req_addr = 32'hC000_0000;
                end
                5: chk("pw_ready5", 32'(ready), 32'd1);
                6: begin
                    chk("pw_abus_b", abus, 32'hB000_0000);
                    req = 1'b0;
                end
                10: chk("pw_abus_c", abus, 32'hC000_0000);
                12: chk("pw_valid_c", 32'(rsp_valid), 32'd1);
                default: ;
            endcase
        end
        chk("pw_pulses", 32'(pulses), 32'd1);
        repeat (2) tick();
`endif

        // WAIT_CYCLES=0 read on the second instance
        req0 = 1'b1; addr0 = 32'hF000_0008;
        tick();
        req0 = 1'b0;
        repeat (OFS) tick();
        chk("w0_abus", abus0, 32'hF000_0008);
        chk("w0_ready", 32'(ready0), 32'd0);
        tick();
        chk("w0_one_access", abus0, ONES);
        chk("w0_valid", 32'(rsp_valid0), 32'd1);
        chk("w0_rdata", rsp_rdata0, 32'h5A5A);
        tick();
        chk("w0_ready_back", 32'(ready0), 32'd1);
        chk("w0_we", 32'(we0), 32'd0);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            req       = ($urandom_range(9) < 6);
            req_we    = $urandom_range(1) == 1;
            req_addr  = $urandom();
            req_wdata = $urandom();
            rst_n     = ($urandom_range(299) != 0);
            tick();
        end
        rst_n = 1'b1;
        req = 1'b0;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 SHALL have parameter BITS, default 32: width of address and data.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra ACCESS cycles per bus transfer, range 0-15.
REQ-003 SHALL have parameter IDLE_ADDR, default all-ones (BITS wide): ABUS value whenever no transfer is active.
REQ-004 SHALL have port CLK, in, 1: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET_N, in, 1: synchronous, active-low reset.
REQ-006 SHALL have port REQ, in, 1: CPU-side request valid.
REQ-007 SHALL have port REQ_WE, in, 1: 1 = write, 0 = read.
REQ-008 SHALL have port REQ_ADDR, in, BITS: transfer address.
REQ-009 SHALL have port REQ_WDATA, in, BITS: write data.
REQ-010 SHALL have port READY, out, 1: request is accepted on the edge where REQ && READY.
REQ-011 SHALL have port RSP_VALID, out, 1: one-cycle completion pulse.
REQ-012 SHALL have port RSP_RDATA, out, BITS: read data, held until the next read completes.
REQ-013 SHALL have port ABUS, out, BITS: peripheral address bus.
REQ-014 SHALL have port DBUS, inout, BITS: shared data bus; driven only during write ACCESS, otherwise all-Z.
REQ-015 SHALL have port WE, out, 1: bus write strobe.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> TURN -> IDLE; ABUS, WE and the DBUS enable SHALL be decoded from registered state only.
REQ-017 IDLE: READY=1 (non-posted build), ABUS=IDLE_ADDR, WE=0, DBUS=Z; on REQ the request is latched and the FSM goes to ACCESS.
REQ-018 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter; ABUS=latched address throughout.
REQ-019 Write ACCESS: WE=1, DBUS=latched wdata for every ACCESS cycle.
REQ-020 Read ACCESS: WE=0, DBUS=Z; DBUS SHALL be sampled into RSP_RDATA on the edge that ends the last ACCESS cycle.
REQ-021 TURN: one cycle with ABUS=IDLE_ADDR, WE=0, DBUS=Z and RSP_VALID=1; then IDLE.
REQ-022 Non-posted latency: request accepted at edge t0 gives ACCESS cycles t0+1..t0+1+WAIT_CYCLES, RSP_VALID in cycle t0+WAIT_CYCLES+2, and READY again in cycle t0+WAIT_CYCLES+3.
REQ-023 A write SHALL NOT alter RSP_RDATA.
REQ-024 REQ inputs SHALL be ignored while READY=0; the latched request SHALL be unaffected by input changes after acceptance.
REQ-025 A read of an undriven (Z) bus SHALL capture the sampled value unmodified; the block has no error response.

Reset
REQ-026 RESET_N=0 at an edge SHALL force IDLE, counter 0, RSP_VALID=0, RSP_RDATA=0, ABUS=IDLE_ADDR, WE=0, DBUS=Z and an empty FIFO from the next cycle, including mid-ACCESS.
REQ-027 A transfer aborted by reset SHALL produce no RSP_VALID.

Configuration
REQ-028 Macro POSTED_WRITE_EN SHALL compile in a 2-entry posted-write FIFO.
REQ-029 With POSTED_WRITE_EN: writes are accepted into the FIFO whenever it is not full and no read is pending, with no RSP_VALID; the FSM issues FIFO entries in order.
REQ-030 With POSTED_WRITE_EN: a read is accepted under the same condition and issued only after the FIFO is empty (program order); only reads pulse RSP_VALID.
REQ-031 With POSTED_WRITE_EN: READY=0 while the FIFO is full or a read is pending; simultaneous push and pop SHALL keep the count unchanged.
REQ-032 Without POSTED_WRITE_EN: there is no FIFO, behaviour is per REQ-017..022, and every transfer pulses RSP_VALID.

Verification
REQ-033 WAIT_CYCLES=1, write 0x0000_0005 to 0xF000_0000 -> WE=1, DBUS=5 for 2 cycles; RSP_VALID 3 cycles after accept; READY 4 cycles after.
REQ-034 Read 0xF000_0004 with the bench driving DBUS=0x1234 during ACCESS -> RSP_RDATA=0x1234 with RSP_VALID; DBUS undriven by the DUT throughout.
REQ-035 RESET_N low in the 2nd ACCESS cycle of a write -> next cycle WE=0, DBUS=Z, ABUS=all-ones; no RSP_VALID.
REQ-036 Back-to-back REQ held high for two writes -> second accepted only when READY returns; ABUS shows IDLE_ADDR for the one TURN cycle between them.
REQ-037 POSTED_WRITE_EN: writes A, B, then read C -> READY=0 after B (FIFO full); bus order A, B, C; single RSP_VALID for C.
REQ-038 WAIT_CYCLES=0, read -> exactly one ACCESS cycle; RSP_VALID 2 cycles after accept.
